// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus transmit sequencer feeding uart_top.
// Host bytes enter over wr_valid/wr_ready; the sequencer pops one byte at a
// time, pulses tx_start and paces the next byte on tx_busy.
module uart_tx_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     flush,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     tx_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] tmo_cnt_q;
    logic [7:0]    tx_data_q;
    logic          overflow_q, tx_err_q;
    logic          wr_en, pop, tmo_fire;

    // Status decoded from registered state only; wr_ready also gated by rst.
    assign level    = level_q;
    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign wr_ready = !full && !rst;
    assign tx_start = (state_q == START);
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign tx_err   = tx_err_q;

    assign wr_en = wr_valid && wr_ready;
    assign pop   = (state_q == IDLE) && !empty && !tx_busy;

    // Sequencer next state; tmo_cnt_q holds WAIT_BUSY cycles already elapsed,
    // so the timeout is decided in the ACK_TIMEOUT-th WAIT_BUSY cycle.
    always_comb begin
        state_d  = state_q;
        tmo_fire = 1'b0;
        unique case (state_q)
            IDLE:      if (pop) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    tmo_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Sequencer state and acknowledge timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == START) begin
                tmo_cnt_q <= '0;
            end else if (state_q == WAIT_BUSY) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    // Pointers and occupancy; flush wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (!wr_en && pop) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Storage array; no reset needed since level gates every read.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr_q] <= wr_data;
    end

    // Popped byte held for uart_top until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q <= '0;
        end else if (pop) begin
            tx_data_q <= mem[rd_ptr_q];
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) overflow_q <= 1'b1;
            if (tmo_fire)              tx_err_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a transaction-level queue model checked every cycle,
// a simple uart_top stand-in driving tx_busy, and directed literal checks.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AT    = 8;
    localparam int FRAME = 20;  // cycles tx_busy stays high per byte

    logic       clk = 1'b0;
    logic       rst, wr_valid, flush, tx_busy;
    logic [7:0] wr_data, tx_data;
    logic       wr_ready, tx_start, empty, full, overflow, tx_err;
    logic [4:0] level;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .ACK_TIMEOUT(AT)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .flush(flush), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .level(level), .empty(empty), .full(full),
        .overflow(overflow), .tx_err(tx_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // uart_top stand-in: 0 = respond to tx_start, 1 = busy held high, 2 = busy held low
    int         busy_mode = 0;
    int         busy_left = 0;
    logic [7:0] rx_q[$];
    logic       st_seen, rst_seen;
    logic [7:0] data_seen;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            st_seen   = tx_start;
            data_seen = tx_data;
            rst_seen  = rst;
            @(posedge clk);
            #1;
            if (busy_left > 0) busy_left--;
            if (rst_seen) begin
                busy_left = 0;
            end else if (busy_mode == 0 && st_seen === 1'b1) begin
                busy_left = FRAME;
                rx_q.push_back(data_seen);
            end
            tx_busy = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'b0 : (busy_left > 0);
        end
    end

    // Model: queue contents, in-flight byte with its start cycle, sticky flags.
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0, m_err = 1'b0, m_active = 1'b0, m_busy_seen = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         m_start_cyc = 0;
    int         cyc = 0;
    int         start_count = 0;
    logic       check_en = 1'b0;
    logic       was_active, do_pop, wr_acc;

    always @(negedge clk) begin
        cyc++;
        if (check_en) begin
            check("level", level, mq.size());
            check("empty", empty, mq.size() == 0);
            check("full", full, mq.size() == DEPTH);
            check("wr_ready", wr_ready, (mq.size() < DEPTH) && !rst);
            check("overflow", overflow, m_ovf);
            check("tx_err", tx_err, m_err);
            check("tx_start", tx_start, m_active && (cyc == m_start_cyc));
            check("tx_data", tx_data, m_data);
            if (tx_start === 1'b1) start_count++;
        end
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0; m_err = 1'b0; m_active = 1'b0; m_data = 8'h00;
        end else begin
            was_active = m_active;
            do_pop     = !was_active && (mq.size() > 0) && !tx_busy;
            wr_acc     = wr_valid && (mq.size() < DEPTH);
            if (wr_valid && mq.size() == DEPTH) m_ovf = 1'b1;
            if (was_active && cyc > m_start_cyc) begin
                if (!m_busy_seen) begin
                    if (tx_busy) begin
                        m_busy_seen = 1'b1;
                    end else if (cyc - m_start_cyc == AT) begin
                        m_err = 1'b1;
                        m_active = 1'b0;
                    end
                end else if (!tx_busy) begin
                    m_active = 1'b0;
                end
            end
            if (do_pop) begin
                m_data = mq.pop_front();
                m_active = 1'b1;
                m_start_cyc = cyc + 1;
                m_busy_seen = 1'b0;
            end
            if (flush) mq.delete();
            else if (wr_acc) mq.push_back(wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin tick(); k++; end
        check({name, "_rx_count"}, rx_q.size(), n);
        k = 0;
        while (tx_busy && k < budget) begin tick(); k++; end
        repeat (3) tick();
    endtask

    task automatic check_rx(input int base, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            check(name, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, base + i);
        end
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got time limit, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    int   sent, k, sc;
    logic seen3, wv;

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; flush = 1'b0;
        repeat (3) tick();
        check_en = 1'b1;
        check("reset_empty", empty, 1);
        check("reset_level", level, 0);
        check("reset_wr_ready", wr_ready, 0);
        rst = 1'b0;
        tick();
        check("post_reset_wr_ready", wr_ready, 1);

        // Single byte: tx_start two cycles after the write edge
        rx_q.delete();
        wr_data = 8'hA5; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
        check("t1_level_n1", level, 1);
        check("t1_start_n1", tx_start, 0);
        tick();
        check("t1_start_n2", tx_start, 1);
        check("t1_data_n2", tx_data, 8'hA5);
        check("t1_level_n2", level, 0);
        wait_rx(1, 200, "t1");
        check_rx(8'hA5, 1, "t1_rx");

        // Burst of 16
        rx_q.delete();
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i + 1); wr_valid = 1'b1;
            check("t2_wr_ready", wr_ready, 1);
            tick();
        end
        wr_valid = 1'b0;
        wait_rx(16, 16 * (FRAME + 10), "t2");
        check_rx(1, 16, "t2_rx");

        // Overflow with tx_busy held high
        rx_q.delete();
        busy_mode = 1; tick(); tick();
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(8'h40 + i); wr_valid = 1'b1;
            tick();
            if (i == 15) begin
                check("t3_full", full, 1);
                check("t3_level16", level, 16);
                check("t3_wr_ready_low", wr_ready, 0);
                check("t3_no_ovf_yet", overflow, 0);
            end
        end
        wr_valid = 1'b0;
        check("t3_overflow", overflow, 1);
        check("t3_level_kept", level, 16);
        busy_mode = 0;
        wait_rx(16, 16 * (FRAME + 10), "t3");
        check_rx(8'h40, 16, "t3_rx");
        check("t3_rx_total", rx_q.size(), 16);

        // Wrap-around while keeping 3..5 entries queued
        rx_q.delete();
        sent = 0; k = 0; seen3 = 1'b0;
        while (sent < 40 && k < 4000) begin
            wv = (level <= 4);
            wr_valid = wv;
            wr_data = 8'(8'h80 + sent);
            if (seen3) check("t4_level_window", (level >= 3) && (level <= 5), 1);
            if (level >= 3) seen3 = 1'b1;
            tick(); k++;
            if (wv) sent++;
        end
        wr_valid = 1'b0;
        check("t4_sent", sent, 40);
        wait_rx(40, 40 * (FRAME + 10), "t4");
        check_rx(8'h80, 40, "t4_rx");

        // Timeout: tx_busy never rises
        busy_mode = 2; tick(); tick();
        wr_data = 8'h3C; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
        tick();
        check("t5_start", tx_start, 1);
        check("t5_data", tx_data, 8'h3C);
        repeat (8) tick();
        check("t5_err_not_yet", tx_err, 0);
        tick();
        check("t5_err", tx_err, 1);
        check("t5_empty", empty, 1);
        wr_data = 8'h5A; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
        tick();
        check("t5_idle_again", tx_start, 1);
        repeat (12) tick();

        // Flush while byte 1 is on the line
        busy_mode = 0; rx_q.delete(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'(8'h11 + i); wr_valid = 1'b1; tick();
        end
        wr_valid = 1'b0;
        k = 0;
        while (!tx_busy && k < 50) begin tick(); k++; end
        check("t6_busy_seen", tx_busy, 1);
        sc = start_count;
        flush = 1'b1; tick(); flush = 1'b0;
        check("t6_level_flushed", level, 0);
        check("t6_empty", empty, 1);
        wait_rx(1, 100, "t6");
        repeat (30) tick();
        check("t6_no_more_starts", start_count, sc);
        check_rx(8'h11, 1, "t6_rx");
        check("t6_rx_total", rx_q.size(), 1);
        check("t6_overflow_kept", overflow, 1);
        check("t6_err_kept", tx_err, 1);

        // Reset mid-frame
        wr_data = 8'h77; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
        k = 0;
        while (!tx_busy && k < 20) begin tick(); k++; end
        check("t7_busy_seen", tx_busy, 1);
        rst = 1'b1; tick();
        check("t7_wr_ready", wr_ready, 0);
        check("t7_start", tx_start, 0);
        check("t7_empty", empty, 1);
        check("t7_full", full, 0);
        check("t7_level", level, 0);
        check("t7_overflow", overflow, 0);
        check("t7_tx_err", tx_err, 0);
        check("t7_tx_data", tx_data, 0);
        rst = 1'b0; tick();
        check("t7_after_wr_ready", wr_ready, 1);
        check("t7_after_start", tx_start, 0);
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
